// File: rtl/elevator_scheduler_if.sv
// Call-button and indicator bundle for the elevator car scheduler.
// The scheduler takes the slave side; call-button logic takes the master side.
interface elevator_scheduler_if #(
  parameter int FLOORS = 4,
  parameter int FW     = 2
);
  logic [FLOORS-1:0] call_req;
  logic [FLOORS-1:0] pending;
  logic [FW-1:0]     cur_floor;
  logic              moving_up;
  logic              moving_down;
  logic              door_open;
  logic              busy;

  modport master (
    output call_req,
    input  pending, cur_floor, moving_up, moving_down, door_open, busy
  );

  modport slave (
    input  call_req,
    output pending, cur_floor, moving_up, moving_down, door_open, busy
  );
endinterface

// File: rtl/elevator_scheduler.sv
// SCAN car-motion scheduler: latches floor calls, picks direction, and times
// floor travel and door dwell in ticks of the divided clock.
module elevator_scheduler #(
  parameter int FLOORS       = 4,
  parameter int FW           = 2,
  parameter int TRAVEL_TICKS = 3,
  parameter int DOOR_TICKS   = 5
) (
  input  logic clk_in,
  input  logic rst,
  input  logic divided_clk,
  elevator_scheduler_if.slave bus
);

  localparam int MAXT = (TRAVEL_TICKS > DOOR_TICKS) ? TRAVEL_TICKS : DOOR_TICKS;
  localparam int TW   = (MAXT > 1) ? $clog2(MAXT) : 1;
  localparam logic [TW-1:0] TRAVEL_LAST = TW'(TRAVEL_TICKS - 1);
  localparam logic [TW-1:0] DOOR_LAST   = TW'(DOOR_TICKS - 1);
  localparam logic [FW:0]   ONE_EXT     = (FW+1)'(1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE_UP   = 2'd1,
    MOVE_DOWN = 2'd2,
    DOOR_OPEN = 2'd3
  } state_t;

  state_t            state_reg, state_next;
  logic              dir_reg, dir_next;
  logic [FW-1:0]     floor_reg, floor_next;
  logic [FLOORS-1:0] pending_reg, pending_next;
  logic [TW-1:0]     tcnt_reg, tcnt_next;
  logic              div_q_reg;

  logic              tick;
  logic [FW:0]       cur_ext;
  logic [FLOORS-1:0] cur_hot, above_vec, below_vec;
  logic [FLOORS-1:0] up_hit_vec, beyond_up_vec, dn_hit_vec, beyond_dn_vec;
  logic [FLOORS-1:0] clr_mask, recall_mask;
  logic              above, below, here, recall;
  logic              at_top, at_bottom, travel_end, door_end;

  assign tick    = divided_clk & ~div_q_reg;
  assign cur_ext = {1'b0, floor_reg};

  // Per-floor relations to the current floor and to the next floor in each direction.
  generate
    for (genvar gi = 0; gi < FLOORS; gi++) begin : g_floor
      localparam logic [FW:0] IDX = (FW+1)'(gi);
      assign cur_hot[gi]       = (IDX == cur_ext);
      assign above_vec[gi]     = pending_reg[gi] && (IDX > cur_ext);
      assign below_vec[gi]     = pending_reg[gi] && (IDX < cur_ext);
      assign up_hit_vec[gi]    = pending_reg[gi] && (IDX == cur_ext + ONE_EXT);
      assign beyond_up_vec[gi] = pending_reg[gi] && (IDX > cur_ext + ONE_EXT);
      assign dn_hit_vec[gi]    = pending_reg[gi] && (IDX + ONE_EXT == cur_ext);
      assign beyond_dn_vec[gi] = pending_reg[gi] && (IDX + ONE_EXT < cur_ext);
    end
  endgenerate

  assign above      = |above_vec;
  assign below      = |below_vec;
  assign here       = |(pending_reg & cur_hot);
  assign at_top     = (floor_reg == FW'(FLOORS - 1));
  assign at_bottom  = (floor_reg == '0);
  assign travel_end = tick && (tcnt_reg == TRAVEL_LAST);
  assign door_end   = tick && (tcnt_reg == DOOR_LAST);

  // A call for the floor the door is already open at extends the dwell instead of latching.
  assign recall_mask = (state_reg == DOOR_OPEN) ? cur_hot : '0;
  assign recall      = |(bus.call_req & recall_mask);

  always_comb begin
    state_next = state_reg;
    dir_next   = dir_reg;
    floor_next = floor_reg;
    clr_mask   = '0;
    tcnt_next  = tick ? tcnt_reg + TW'(1) : tcnt_reg;
    case (state_reg)
      IDLE: begin
        tcnt_next = '0;
        if (here) begin
          state_next = DOOR_OPEN;
          clr_mask   = cur_hot;
        end else if (dir_reg) begin
          if (above) begin
            state_next = MOVE_UP;
            dir_next   = 1'b1;
          end else if (below) begin
            state_next = MOVE_DOWN;
            dir_next   = 1'b0;
          end
        end else begin
          if (below) begin
            state_next = MOVE_DOWN;
            dir_next   = 1'b0;
          end else if (above) begin
            state_next = MOVE_UP;
            dir_next   = 1'b1;
          end
        end
      end
      MOVE_UP: begin
        if (travel_end) begin
          tcnt_next = '0;
          if (!at_top) floor_next = floor_reg + FW'(1);
          if (|up_hit_vec) begin
            state_next = DOOR_OPEN;
            clr_mask   = up_hit_vec;
          end else if (!(|beyond_up_vec)) begin
            state_next = IDLE;
          end
        end
      end
      MOVE_DOWN: begin
        if (travel_end) begin
          tcnt_next = '0;
          if (!at_bottom) floor_next = floor_reg - FW'(1);
          if (|dn_hit_vec) begin
            state_next = DOOR_OPEN;
            clr_mask   = dn_hit_vec;
          end else if (!(|beyond_dn_vec)) begin
            state_next = IDLE;
          end
        end
      end
      DOOR_OPEN: begin
        if (recall) begin
          tcnt_next = '0;
        end else if (door_end) begin
          tcnt_next  = '0;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        tcnt_next  = '0;
      end
    endcase
    // Clear is applied last so a same-edge call to a served floor is absorbed.
    pending_next = (pending_reg | (bus.call_req & ~recall_mask)) & ~clr_mask;
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      dir_reg     <= 1'b1;
      floor_reg   <= '0;
      pending_reg <= '0;
      tcnt_reg    <= '0;
      div_q_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      dir_reg     <= dir_next;
      floor_reg   <= floor_next;
      pending_reg <= pending_next;
      tcnt_reg    <= tcnt_next;
      div_q_reg   <= divided_clk;
    end
  end

  assign bus.pending     = pending_reg;
  assign bus.cur_floor   = floor_reg;
  assign bus.moving_up   = (state_reg == MOVE_UP);
  assign bus.moving_down = (state_reg == MOVE_DOWN);
  assign bus.door_open   = (state_reg == DOOR_OPEN);
  assign bus.busy        = (state_reg != IDLE) || (pending_reg != '0);

endmodule

// File: doc/elevator_scheduler.md
# elevator_scheduler

Car-motion scheduler for a single elevator car serving FLOORS floors. It latches floor calls and chooses the travel direction using SCAN. Floor-to-floor travel and door dwell are timed by counting rising edges of `divided_clk`, the 50 Hz divided clock. The block sits between the call-button logic and the floor/door indicators, on the same `clk_in` domain as the clock divider.

## Interface
Parameters:
- FLOORS, 4, number of floors (2..8); floor index 0 is the bottom floor
- FW, 2, width of floor index; must satisfy 2^FW >= FLOORS
- TRAVEL_TICKS, 3, ticks needed to move one floor (>=1)
- DOOR_TICKS, 5, ticks the door stays open (>=1)

Ports (one clock; reset is asynchronous and active-high):
- clk_in  in  1  system clock, 100 MHz
- rst  in  1  asynchronous, active-high reset
- divided_clk  in  1  divided clock, sampled in the `clk_in` domain (synchronous, no CDC)
- call_req  in  FLOORS  one-cycle call pulses, one bit per floor; multiple bits may be high
- pending  out  FLOORS  latched, unserved calls
- cur_floor  out  FW  current floor index
- moving_up  out  1  car is in MOVE_UP
- moving_down  out  1  car is in MOVE_DOWN
- door_open  out  1  car is in DOOR_OPEN
- busy  out  1  state != IDLE, or pending != 0

## Operation
- Tick detector:
  - `div_q` is a registered copy of `divided_clk`.
  - `tick = divided_clk & ~div_q`.
  - This gives exactly one tick per divided-clock period.
- Tick counter `tcnt`:
  - Cleared on every state entry.
  - Increments on each tick.
  - A timed phase ends on the tick where `tcnt == N-1`, so a phase lasts exactly N ticks.
- Direction register `dir`:
  - Values: 1 = up, 0 = down.
  - Updated whenever MOVE_UP or MOVE_DOWN is entered.
- Call latching: `pending[f]` is set on `call_req[f]`, except for a call to `cur_floor` while in DOOR_OPEN. That call restarts the door timer (`tcnt` cleared) and is not latched.
- Signal definitions:
  - `above` = any pending bit with index > `cur_floor`.
  - `below` = any pending bit with index < `cur_floor`.
  - `here` = `pending[cur_floor]`.
- States and transitions:
  - IDLE
    - If `here`: go to DOOR_OPEN and clear `pending[cur_floor]`.
    - Else if `dir`=1: go to MOVE_UP if `above`, otherwise MOVE_DOWN if `below`.
    - Else (`dir`=0): go to MOVE_DOWN if `below`, otherwise MOVE_UP if `above`.
    - Else stay in IDLE.
  - MOVE_UP
    - At the end of the travel phase, `cur_floor` increments.
    - If `pending[cur_floor+1]`: go to DOOR_OPEN and clear that bit.
    - Else if any call lies above `cur_floor+1`: re-enter MOVE_UP (`tcnt` cleared).
    - Else go to IDLE.
  - MOVE_DOWN: mirror of MOVE_UP, with `cur_floor` decrementing.
  - DOOR_OPEN: at the end of the door phase, go to IDLE.
- Call/clear collision: if a set and a clear hit the same bit on the same edge, the clear wins and the call is absorbed as served.
- Range guard: `cur_floor` never goes below 0 or above FLOORS-1. Call bits for unused indices do not exist.
- Outputs: `moving_up`, `moving_down` and `door_open` decode the registered state, so they are glitch-free.

## Timing
- Reset values:
  - state IDLE, `dir` = 1, `cur_floor` = 0, `pending` = 0, `tcnt` = 0, `div_q` = 0.
  - All outputs 0.
- Call latency: a `call_req` pulse at edge t makes `pending` visible after edge t.
- IDLE decision: made from registered `pending` on edge t+1. The new state is visible after t+1, so an idle car responds 2 cycles after the call.
- Tick latency: tick is combinational from `divided_clk`. The phase-ending tick changes state on the same edge that `divided_clk` is first sampled high.
- Door open to close: DOOR_TICKS ticks. There is no extra gap cycle when going DOOR_OPEN -> IDLE -> MOVE.
  - IDLE costs exactly one `clk_in` cycle.
- Rst mid-operation: all state is cleared immediately. After release, the car restarts at floor 0 with no pending calls.

## Test plan
Bench drives `divided_clk` with period 8 (4 high / 4 low), giving one tick every 8 cycles. Default parameters apply.

- Reset: assert `rst` mid-MOVE_UP with `cur_floor` = 2 -> all outputs are 0 and `cur_floor` = 0 while `rst` is high.
- Local call: `call_req` = 0001 at floor 0 -> `pending` = 0001 for 1 cycle, then `door_open` = 1 for 5 ticks (40 cycles), then IDLE with `busy` = 0.
- Travel: `call_req` = 1000 -> `moving_up` for 9 ticks, `cur_floor` stepping 1, 2, 3 every 3 ticks, then `door_open` for 5 ticks with `pending` = 0.
- SCAN: at floor 1 with `dir` up, calls 0001 and 0100 together -> the car serves floor 2 first, then reverses and serves floor 0.
- Door re-call: `call_req[cur_floor]` on door tick 4 -> `tcnt` restarts, the door stays open 5 more ticks, and `pending` stays 0.
- Collision: `call_req[2]` pulsed on the same edge the car arrives at floor 2 -> bit 2 is cleared, with exactly one DOOR_OPEN.
